// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl
// Owns the single port of the instruction RAM. In run mode the CPU fetches
// through it combinationally. A load session stalls the CPU, packs loader
// bytes into little-endian 32-bit words and writes them from word 0 upward.
// Optional build macro: IMEM_LOADER_CSUM_EN enables the XOR checksum of
// accepted bytes on ld_csum; without it ld_csum is constant zero.

module imem_loader_ctrl #(
    parameter int          DEPTH    = 64,
    parameter int          AW       = 6,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   cpu_addr,
    output logic [31:0]   cpu_instr,
    output logic          cpu_stall,
    input  logic          ld_start,
    input  logic [7:0]    ld_byte,
    input  logic          ld_byte_valid,
    output logic          ld_byte_ready,
    input  logic          ld_last,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ld_err,
    output logic [7:0]    ld_csum,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Word index is one bit wider than the RAM address so it can hold DEPTH,
    // the saturated "RAM full" value that marks overflow.
    localparam logic [AW:0] DEPTH_IDX = (AW+1)'(DEPTH);
    localparam logic [AW:0] IDX_ONE   = (AW+1)'(1);

    state_t      state;
    state_t      state_next;
    logic [AW:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic        last_seen;
    logic        accept;

    // Address bits below word alignment and above the RAM size are ignored.
    logic unused_cpu_addr_bits;
    assign unused_cpu_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

    assign accept = (state == COLLECT) && ld_byte_valid;

    // State register; reset always returns the RAM to the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and port muxing between CPU fetch and loader writes.
    always_comb begin
        state_next    = state;
        cpu_instr     = NOP_WORD;
        cpu_stall     = 1'b1;
        ld_busy       = 1'b1;
        ld_byte_ready = 1'b0;
        ld_done       = 1'b0;
        mem_addr      = word_idx[AW-1:0];
        mem_wdata     = 32'h0000_0000;
        mem_we        = 1'b0;
        case (state)
            RUN: begin
                cpu_instr = mem_rdata;
                cpu_stall = 1'b0;
                ld_busy   = 1'b0;
                mem_addr  = cpu_addr[AW+1:2];
                if (ld_start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                ld_byte_ready = 1'b1;
                if (ld_byte_valid && ((byte_cnt == 2'd3) || ld_last)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_wdata  = word_buf;
                mem_we     = (word_idx != DEPTH_IDX);
                state_next = last_seen ? DONE : COLLECT;
            end
            DONE: begin
                ld_done    = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Byte packing, word index and sticky overflow flag for the session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx  <= '0;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'h0000_0000;
            last_seen <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_start) begin
                        word_idx  <= '0;
                        byte_cnt  <= 2'd0;
                        word_buf  <= 32'h0000_0000;
                        last_seen <= 1'b0;
                        ld_err    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= ld_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (ld_last) begin
                            last_seen <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Buffer clears so a short final word has zero upper bytes.
                    word_buf <= 32'h0000_0000;
                    byte_cnt <= 2'd0;
                    if (word_idx == DEPTH_IDX) begin
                        ld_err <= 1'b1;
                    end else begin
                        word_idx <= word_idx + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;

    // Running XOR of every accepted byte, overflow bytes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else if ((state == RUN) && ld_start) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            csum_q <= csum_q ^ ld_byte;
        end
    end

    assign ld_csum = csum_q;
`else
    assign ld_csum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl
// Bench for imem_loader_ctrl with a behavioural 64-word RAM. Expected RAM
// writes are queued when bytes are driven and popped when mem_we is seen.
// Honours IMEM_LOADER_CSUM_EN for the checksum expectations.

module tb_imem_loader_ctrl;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic        ld_byte_ready;
    logic        ld_last;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic [7:0]  ld_csum;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];
    logic        preload_en;
    logic [5:0]  preload_addr;
    logic [31:0] preload_data;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] cpu_addr;
        logic [31:0] exp_instr;
    } fetch_vec_t;

    wr_t        exp_q[$];
    fetch_vec_t fv[6];

    int total = 0;
    int bad = 0;
    int stall_cycles = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    imem_loader_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_instr    (cpu_instr),
        .cpu_stall    (cpu_stall),
        .ld_start     (ld_start),
        .ld_byte      (ld_byte),
        .ld_byte_valid(ld_byte_valid),
        .ld_byte_ready(ld_byte_ready),
        .ld_last      (ld_last),
        .ld_busy      (ld_busy),
        .ld_done      (ld_done),
        .ld_err       (ld_err),
        .ld_csum      (ld_csum),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    // Behavioural RAM: combinational read, write on rising edge, bench preload port.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end else if (preload_en) begin
            ram[preload_addr] <= preload_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for RAM writes plus stall/NOP/done bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", {26'd0, mem_addr}, e.addr);
                checkOutput("wr_data", mem_wdata, e.data);
            end
        end
        if (rst_n && cpu_stall) begin
            stall_cycles++;
            checkOutput("nop_while_stalled", cpu_instr, NOP);
        end
        if (rst_n) begin
            checkOutput("busy_eq_stall", {31'd0, ld_busy}, {31'd0, cpu_stall});
        end
        if (rst_n && ld_done) begin
            done_count++;
        end
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        @(negedge clk);
        preload_en   = 1'b0;
    endtask

    task automatic startSession();
        stall_cycles = 0;
        done_count   = 0;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offer one byte, wait (bounded) for acceptance, return at the next falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        int g;
        g = 0;
        ld_byte       = b;
        ld_byte_valid = 1'b1;
        ld_last       = last;
        while (!ld_byte_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got ready 0 expected ready 1");
        end
        @(negedge clk);
    endtask

    task automatic finishSession();
        int g;
        g = 0;
        ld_byte_valid = 1'b0;
        ld_last       = 1'b0;
        while (cpu_stall && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) begin
            total++;
            bad++;
            $display("[TB] FAIL session_end_timeout: got stall 1 expected 0");
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        logic [7:0]  csum_exp;

        rst_n         = 1'b0;
        cpu_addr      = 32'h0;
        ld_start      = 1'b0;
        ld_byte       = 8'h00;
        ld_byte_valid = 1'b0;
        ld_last       = 1'b0;
        preload_en    = 1'b0;
        preload_addr  = 6'd0;
        preload_data  = 32'h0;

        @(negedge clk);
        preload(6'd0,  32'h11111111);
        preload(6'd2,  32'hDEADBEEF);
        preload(6'd5,  32'h0BADC0DE);
        preload(6'd63, 32'hCAFEF00D);

        // Reset values
        cpu_addr = 32'h8;
        #1;
        checkOutput("rst_stall", {31'd0, cpu_stall}, 32'd0);
        checkOutput("rst_busy",  {31'd0, ld_busy}, 32'd0);
        checkOutput("rst_done",  {31'd0, ld_done}, 32'd0);
        checkOutput("rst_err",   {31'd0, ld_err}, 32'd0);
        checkOutput("rst_ready", {31'd0, ld_byte_ready}, 32'd0);
        checkOutput("rst_we",    {31'd0, mem_we}, 32'd0);
        checkOutput("rst_csum",  {24'd0, ld_csum}, 32'd0);
        checkOutput("rst_instr", cpu_instr, 32'hDEADBEEF);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fetch vectors
        fv[0] = '{32'h0000_0008, 32'hDEADBEEF};
        fv[1] = '{32'h0000_000B, 32'hDEADBEEF};
        fv[2] = '{32'h0000_0000, 32'h11111111};
        fv[3] = '{32'h0000_0014, 32'h0BADC0DE};
        fv[4] = '{32'h0000_00FC, 32'hCAFEF00D};
        fv[5] = '{32'h0000_0102, 32'h11111111};
        for (int i = 0; i < 6; i++) begin
            cpu_addr = fv[i].cpu_addr;
            #1;
            checkOutput("fetch_instr", cpu_instr, fv[i].exp_instr);
            checkOutput("fetch_stall", {31'd0, cpu_stall}, 32'd0);
        end
        cpu_addr = 32'h0000_0100;
        @(negedge clk);

        // Single word, last on 4th byte
        exp_q.push_back('{32'd0, 32'h12345678});
        startSession();
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h12, 1'b1);
        finishSession();
        checkOutput("s1_stall_cycles", stall_cycles, 32'd6);
        checkOutput("s1_done_pulses", done_count, 32'd1);
        checkOutput("s1_pending", exp_q.size(), 32'd0);
        cpu_addr = 32'h0;
        #1;
        checkOutput("s1_fetch", cpu_instr, 32'h12345678);

        // Six bytes, short final word
        exp_q.push_back('{32'd0, 32'h04030201});
        exp_q.push_back('{32'd1, 32'h00000605});
        startSession();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(8'(i), (i == 6));
        end
        finishSession();
        checkOutput("s2_stall_cycles", stall_cycles, 32'd9);
        checkOutput("s2_done_pulses", done_count, 32'd1);
        checkOutput("s2_pending", exp_q.size(), 32'd0);
        checkOutput("s2_err", {31'd0, ld_err}, 32'd0);
`ifdef IMEM_LOADER_CSUM_EN
        checkOutput("s2_csum", {24'd0, ld_csum}, 32'h07);
`else
        checkOutput("s2_csum", {24'd0, ld_csum}, 32'h00);
`endif
        cpu_addr = 32'h4;
        #1;
        checkOutput("s2_fetch", cpu_instr, 32'h00000605);

        // Overflow: 65 full words
        csum_exp = 8'h00;
        for (int wi = 0; wi < 64; wi++) begin
            w = {8'(wi*4+3), 8'(wi*4+2), 8'(wi*4+1), 8'(wi*4)};
            exp_q.push_back('{32'(wi), w});
        end
        startSession();
        for (int wi = 0; wi < 65; wi++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(wi*4+k);
                csum_exp = csum_exp ^ b;
                applyStimulus(b, (wi == 64) && (k == 3));
            end
        end
        finishSession();
        checkOutput("s3_pending", exp_q.size(), 32'd0);
        checkOutput("s3_done_pulses", done_count, 32'd1);
        checkOutput("s3_err", {31'd0, ld_err}, 32'd1);
`ifdef IMEM_LOADER_CSUM_EN
        checkOutput("s3_csum", {24'd0, ld_csum}, {24'd0, csum_exp});
`else
        checkOutput("s3_csum", {24'd0, ld_csum}, 32'h00);
`endif
        repeat (5) @(negedge clk);
        #1;
        checkOutput("s3_err_sticky", {31'd0, ld_err}, 32'd1);
        cpu_addr = 32'hFC;
        #1;
        checkOutput("s3_fetch_63", cpu_instr, 32'hFFFEFDFC);
        cpu_addr = 32'h0;
        #1;
        checkOutput("s3_fetch_0", cpu_instr, 32'h03020100);
        @(negedge clk);

        // Reset mid-word
        startSession();
        #1;
        checkOutput("s4_err_cleared", {31'd0, ld_err}, 32'd0);
        checkOutput("s4_csum_cleared", {24'd0, ld_csum}, 32'd0);
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        rst_n = 1'b0;
        ld_byte_valid = 1'b0;
        #1;
        checkOutput("s4_rst_stall", {31'd0, cpu_stall}, 32'd0);
        checkOutput("s4_rst_busy",  {31'd0, ld_busy}, 32'd0);
        checkOutput("s4_rst_ready", {31'd0, ld_byte_ready}, 32'd0);
        checkOutput("s4_rst_we",    {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("s4_no_write", exp_q.size(), 32'd0);
        checkOutput("s4_ram_kept", ram[0], 32'h03020100);
        @(negedge clk);

        // Fresh session after reset starts at word 0, checksum pattern
        exp_q.push_back('{32'd0, 32'hAAF00FFF});
        startSession();
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'hAA, 1'b1);
        finishSession();
        checkOutput("s5_pending", exp_q.size(), 32'd0);
        checkOutput("s5_stall_cycles", stall_cycles, 32'd6);
        checkOutput("s5_err", {31'd0, ld_err}, 32'd0);
`ifdef IMEM_LOADER_CSUM_EN
        checkOutput("s5_csum", {24'd0, ld_csum}, 32'hAA);
`else
        checkOutput("s5_csum", {24'd0, ld_csum}, 32'h00);
`endif
        repeat (3) @(negedge clk);
        #1;
`ifdef IMEM_LOADER_CSUM_EN
        checkOutput("s5_csum_hold", {24'd0, ld_csum}, 32'hAA);
`else
        checkOutput("s5_csum_hold", {24'd0, ld_csum}, 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
